// File: rtl/seq_detector.sv
// seq_detector
//
// Configurable symbol-sequence detector. A short history of accepted symbols
// is compared against a loaded pattern of up to DEPTH symbols. Each
// occurrence produces a one-cycle registered match pulse and a saturating
// match count. match_hold stays up while the final pattern symbol keeps
// repeating.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   reset           asynchronous, active-high reset
//   in_valid_i      one symbol on in_sym_i is accepted at this edge
//   in_sym_i        input symbol (SYM_W bits)
//   cfg_load_i      load pattern/length/overlap; clears fill, hold and count
//   cfg_pattern_i   pattern, symbol i (0 = first expected) at [i*SYM_W +: SYM_W]
//   cfg_len_i       active pattern length in symbols (clamped to DEPTH, 0 = off)
//   cfg_overlap_i   1 = overlapping detection, 0 = non-overlapping
//   count_clr_i     synchronous clear of the match counter (wins over a match)
//   match_o         one-cycle pulse the cycle after a matching symbol
//   match_hold_o    high from a match while the last pattern symbol repeats
//   match_count_o   saturating number of matches
//   count_sat_o     high while match_count_o is all ones
module seq_detector #(
    parameter int SYM_W = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid_i,
    input  logic [SYM_W-1:0]       in_sym_i,
    input  logic                   cfg_load_i,
    input  logic [DEPTH*SYM_W-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0]       cfg_len_i,
    input  logic                   cfg_overlap_i,
    input  logic                   count_clr_i,
    output logic                   match_o,
    output logic                   match_hold_o,
    output logic [CNT_W-1:0]       match_count_o,
    output logic                   count_sat_o
);

    localparam int               IDX_W   = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    // hist_q[0] is the newest accepted symbol, hist_q[DEPTH-1] the oldest.
    logic [SYM_W-1:0] hist_q [DEPTH];
    logic [SYM_W-1:0] hist_d [DEPTH];
    logic [SYM_W-1:0] pat_q  [DEPTH];
    logic [SYM_W-1:0] pat_d  [DEPTH];
    logic [SYM_W-1:0] shifted[DEPTH];

    logic [LEN_W-1:0] fill_q, fill_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             overlap_q, overlap_d;
    logic             match_q, match_d;
    logic             hold_q, hold_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             accept;
    logic             hit;
    logic [LEN_W-1:0] fillInc;
    logic [SYM_W-1:0] lastSym;
    int               patIdx;
    int               lastIdx;

    // Next-state logic. The match decision is taken on the history as it will
    // look after this edge: the incoming symbol shifted in at position 0.
    // The newest len symbols, read oldest first, must equal pattern 0..len-1,
    // so history position j lines up with pattern symbol len-1-j.
    always_comb begin
        accept = in_valid_i && !cfg_load_i;

        shifted[0] = in_sym_i;
        for (int k = 1; k < DEPTH; k++) begin
            shifted[k] = hist_q[k-1];
        end

        fillInc = (fill_q == DEPTH_L) ? fill_q : fill_q + LEN_W'(1);

        patIdx = 0;
        hit    = (len_q != '0) && (fillInc >= len_q);
        for (int j = 0; j < DEPTH; j++) begin
            if (LEN_W'(j) < len_q) begin
                patIdx = int'(len_q) - 1 - j;
                if (shifted[j] != pat_q[patIdx[IDX_W-1:0]]) begin
                    hit = 1'b0;
                end
            end
        end

        lastIdx = int'(len_q) - 1;
        lastSym = (len_q != '0) ? pat_q[lastIdx[IDX_W-1:0]] : '0;

        hist_d    = hist_q;
        pat_d     = pat_q;
        fill_d    = fill_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hold_d    = hold_q;
        count_d   = count_q;
        match_d   = 1'b0;

        if (cfg_load_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pat_d[i] = cfg_pattern_i[i*SYM_W +: SYM_W];
            end
            len_d     = (cfg_len_i > DEPTH_L) ? DEPTH_L : cfg_len_i;
            overlap_d = cfg_overlap_i;
            fill_d    = '0;
            hold_d    = 1'b0;
            count_d   = '0;
        end else begin
            match_d = accept && hit;
            if (accept) begin
                hist_d = shifted;
                // Non-overlapping mode starts from scratch after a match so no
                // symbol is shared between two occurrences.
                fill_d = (hit && !overlap_q) ? '0 : fillInc;
                if (hit) begin
                    hold_d = 1'b1;
                end else if (in_sym_i != lastSym) begin
                    hold_d = 1'b0;
                end
            end
            if (count_clr_i) begin
                count_d = '0;
            end else if (accept && hit && !(&count_q)) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                hist_q[k] <= '0;
                pat_q[k]  <= '0;
            end
            fill_q    <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            match_q   <= 1'b0;
            hold_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            hist_q    <= hist_d;
            pat_q     <= pat_d;
            fill_q    <= fill_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            match_q   <= match_d;
            hold_q    <= hold_d;
            count_q   <= count_d;
        end
    end

    assign match_o       = match_q;
    assign match_hold_o  = hold_q;
    assign match_count_o = count_q;
    assign count_sat_o   = &count_q;

endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector
//
// Scoreboard bench for seq_detector (SYM_W=2, DEPTH=4, CNT_W=8). The driver
// applies one cycle of stimulus at a time, steps a queue-based reference
// model and pushes the expected outputs; a monitor pops and compares them
// just after each rising edge.
module tb_seq_detector;

    localparam int SYM_W = 2;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LEN_W = 3;
    localparam int CMAX  = 255;

    logic                   clk;
    logic                   reset;
    logic                   in_valid_i;
    logic [SYM_W-1:0]       in_sym_i;
    logic                   cfg_load_i;
    logic [DEPTH*SYM_W-1:0] cfg_pattern_i;
    logic [LEN_W-1:0]       cfg_len_i;
    logic                   cfg_overlap_i;
    logic                   count_clr_i;
    logic                   match_o;
    logic                   match_hold_o;
    logic [CNT_W-1:0]       match_count_o;
    logic                   count_sat_o;

    seq_detector #(
        .SYM_W(SYM_W),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W),
        .LEN_W(LEN_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid_i   (in_valid_i),
        .in_sym_i     (in_sym_i),
        .cfg_load_i   (cfg_load_i),
        .cfg_pattern_i(cfg_pattern_i),
        .cfg_len_i    (cfg_len_i),
        .cfg_overlap_i(cfg_overlap_i),
        .count_clr_i  (count_clr_i),
        .match_o      (match_o),
        .match_hold_o (match_hold_o),
        .match_count_o(match_count_o),
        .count_sat_o  (count_sat_o)
    );

    typedef struct {
        bit m;
        bit h;
        int cnt;
        bit sat;
    } exp_t;

    exp_t expQ[$];
    int   checks     = 0;
    int   errors     = 0;
    int   matchSeen  = 0;

    // Reference model state: the symbols that still count towards a match,
    // oldest first, plus the loaded configuration.
    int   win[$];
    int   mPat[4];
    int   mLen;
    bit   mOvl;
    bit   mHold;
    int   mCnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every driven cycle produces one expected entry.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (match_o) matchSeen++;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("match",       int'(match_o),       int'(e.m));
            checkOutput("match_hold",  int'(match_hold_o),  int'(e.h));
            checkOutput("match_count", int'(match_count_o), e.cnt);
            checkOutput("count_sat",   int'(count_sat_o),   int'(e.sat));
        end
    end

    function automatic logic [7:0] packPat(input int a, input int b, input int c, input int d);
        logic [7:0] p;
        p[1:0] = 2'(a);
        p[3:2] = 2'(b);
        p[5:4] = 2'(c);
        p[7:6] = 2'(d);
        return p;
    endfunction

    task automatic modelReset();
        win.delete();
        for (int i = 0; i < 4; i++) mPat[i] = 0;
        mLen  = 0;
        mOvl  = 1'b0;
        mHold = 1'b0;
        mCnt  = 0;
    endtask

    // Step the model by one clock edge and return the expected outputs.
    task automatic modelStep(input bit valid, input int sym, input bit load,
                             input logic [7:0] pat, input int len, input bit ovl,
                             input bit clr, output exp_t e);
        bit hit;
        hit = 1'b0;
        if (load) begin
            for (int i = 0; i < 4; i++) mPat[i] = int'(pat[2*i +: 2]);
            mLen  = (len > DEPTH) ? DEPTH : len;
            mOvl  = ovl;
            win.delete();
            mHold = 1'b0;
            mCnt  = 0;
        end else begin
            if (valid) begin
                win.push_back(sym);
                if (win.size() > DEPTH) void'(win.pop_front());
                if (mLen > 0 && win.size() >= mLen) begin
                    hit = 1'b1;
                    for (int i = 0; i < mLen; i++) begin
                        if (win[win.size() - mLen + i] != mPat[i]) hit = 1'b0;
                    end
                end
                if (hit) begin
                    mHold = 1'b1;
                    if (!mOvl) win.delete();
                end else if (mHold && sym != mPat[mLen-1]) begin
                    mHold = 1'b0;
                end
            end
            if (clr) mCnt = 0;
            else if (hit && mCnt < CMAX) mCnt++;
        end
        e.m   = hit;
        e.h   = mHold;
        e.cnt = mCnt;
        e.sat = (mCnt == CMAX);
    endtask

    // One cycle of stimulus: drive at the falling edge, record the expected
    // response, then return the inputs to idle just after the rising edge.
    task automatic applyStimulus(input bit valid, input int sym, input bit load,
                                 input logic [7:0] pat, input int len, input bit ovl,
                                 input bit clr);
        exp_t e;
        @(negedge clk);
        in_valid_i    = valid;
        in_sym_i      = 2'(sym);
        cfg_load_i    = load;
        cfg_pattern_i = pat;
        cfg_len_i     = 3'(len);
        cfg_overlap_i = ovl;
        count_clr_i   = clr;
        modelStep(valid, sym, load, pat, len, ovl, clr, e);
        expQ.push_back(e);
        @(posedge clk);
        #1;
        in_valid_i  = 1'b0;
        cfg_load_i  = 1'b0;
        count_clr_i = 1'b0;
    endtask

    task automatic loadCfg(input logic [7:0] pat, input int len, input bit ovl);
        applyStimulus(1'b0, 0, 1'b1, pat, len, ovl, 1'b0);
    endtask

    task automatic sendSym(input int sym);
        applyStimulus(1'b1, sym, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset      = 1'b1;
        in_valid_i = 1'b0;
        cfg_load_i = 1'b0;
        #1;
        checkOutput("reset_match", int'(match_o),       0);
        checkOutput("reset_hold",  int'(match_hold_o),  0);
        checkOutput("reset_count", int'(match_count_o), 0);
        checkOutput("reset_sat",   int'(count_sat_o),   0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int base;
        int r;
        reset         = 1'b1;
        in_valid_i    = 1'b0;
        in_sym_i      = '0;
        cfg_load_i    = 1'b0;
        cfg_pattern_i = '0;
        cfg_len_i     = '0;
        cfg_overlap_i = 1'b0;
        count_clr_i   = 1'b0;
        modelReset();
        #2;
        checkOutput("por_match", int'(match_o),       0);
        checkOutput("por_hold",  int'(match_hold_o),  0);
        checkOutput("por_count", int'(match_count_o), 0);
        checkOutput("por_sat",   int'(count_sat_o),   0);
        @(negedge clk);
        reset = 1'b0;

        // Pattern {1,2}: hold across the repeated 2s, dropped by 0.
        loadCfg(packPat(1, 2, 0, 0), 2, 1'b1);
        base = matchSeen;
        sendSym(1); sendSym(2); sendSym(2); sendSym(2); sendSym(0); idle();
        checkOutput("p12_matches", matchSeen - base, 1);
        checkOutput("p12_count", int'(match_count_o), 1);

        // Pattern {1,1,1}, five 1s, overlapping then non-overlapping.
        loadCfg(packPat(1, 1, 1, 0), 3, 1'b1);
        base = matchSeen;
        repeat (5) sendSym(1);
        idle();
        checkOutput("p111_ovl_matches", matchSeen - base, 3);
        loadCfg(packPat(1, 1, 1, 0), 3, 1'b0);
        base = matchSeen;
        repeat (5) sendSym(1);
        idle();
        checkOutput("p111_novl_matches", matchSeen - base, 1);

        // Pattern {3,0,2} with invalid gaps, then a broken stream.
        loadCfg(packPat(3, 0, 2, 0), 3, 1'b1);
        base = matchSeen;
        sendSym(3); idle(); idle(); sendSym(0); idle(); idle(); sendSym(2); idle();
        checkOutput("p302_gap_matches", matchSeen - base, 1);
        base = matchSeen;
        sendSym(3); sendSym(0); sendSym(1); sendSym(2); idle();
        checkOutput("p302_broken_matches", matchSeen - base, 0);

        // Partial match discarded by reset and by a reload.
        loadCfg(packPat(1, 2, 3, 0), 3, 1'b1);
        base = matchSeen;
        sendSym(1); sendSym(2);
        doReset();
        sendSym(3); idle();
        checkOutput("p123_after_reset", matchSeen - base, 0);
        loadCfg(packPat(1, 2, 3, 0), 3, 1'b1);
        sendSym(1); sendSym(2);
        loadCfg(packPat(1, 2, 3, 0), 3, 1'b1);
        sendSym(3); idle();
        checkOutput("p123_after_reload", matchSeen - base, 0);
        sendSym(1); sendSym(2); sendSym(3); idle();
        checkOutput("p123_full", matchSeen - base, 1);

        // Length clamping and length zero.
        loadCfg(packPat(1, 2, 3, 0), 7, 1'b1);
        base = matchSeen;
        sendSym(1); sendSym(2); sendSym(3); idle();
        checkOutput("len7_partial", matchSeen - base, 0);
        sendSym(0); idle();
        checkOutput("len7_full", matchSeen - base, 1);
        loadCfg(packPat(0, 0, 0, 0), 0, 1'b1);
        base = matchSeen;
        repeat (12) sendSym(0);
        for (int i = 0; i < 12; i++) sendSym($urandom_range(0, 3));
        idle();
        checkOutput("len0_matches", matchSeen - base, 0);

        // Counter saturation and clear racing a match.
        loadCfg(packPat(1, 0, 0, 0), 1, 1'b1);
        repeat (260) sendSym(1);
        idle();
        checkOutput("sat_count", int'(match_count_o), CMAX);
        checkOutput("sat_flag", int'(count_sat_o), 1);
        applyStimulus(1'b1, 1, 1'b0, 8'h00, 0, 1'b0, 1'b1);
        idle();
        checkOutput("clr_vs_match", int'(match_count_o), 0);

        // Randomized traffic with reloads, clears and resets.
        for (int t = 0; t < 40; t++) begin
            loadCfg(8'($urandom), ($urandom_range(0, 9) < 8) ? $urandom_range(1, 3) : $urandom_range(0, 7),
                    1'($urandom_range(0, 1)));
            for (int c = 0; c < 40; c++) begin
                r = $urandom_range(0, 99);
                if (r < 2) begin
                    doReset();
                end else if (r < 5) begin
                    applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1,
                                  8'($urandom), $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'b0);
                end else begin
                    applyStimulus((r % 4) != 0, $urandom_range(0, 3), 1'b0, 8'h00, 0, 1'b0,
                                  $urandom_range(0, 19) == 0);
                end
            end
        end

        idle();
        @(negedge clk);
        checkOutput("queue_drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
